// File: rtl/div_seq_ctrl_pkg.sv
// Shared types and defaults for the sequential divide controller.
package div_seq_ctrl_pkg;

  localparam int unsigned DivDataW = 32;
  localparam int unsigned DivCntW  = 6;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StIter = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Request/response bundle between EX-stage issue logic and the divide controller.
interface div_seq_ctrl_if
  import div_seq_ctrl_pkg::*;
#(
  parameter int unsigned DataW = DivDataW
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic             is_unsigned;
  logic             use_mod;
  logic [DataW-1:0] src1;
  logic [DataW-1:0] src2;
  logic             out_valid;
  logic             out_ready;
  logic [DataW-1:0] result;
  logic             busy;

  modport master (
    output flush, in_valid, is_unsigned, use_mod, src1, src2, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, is_unsigned, use_mod, src1, src2, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/div_seq_ctrl_step.sv
// One combinational radix-2 restoring step: shift {rem,quo} left, subtract divisor if it fits.
module div_seq_ctrl_step #(
  parameter int unsigned DataW = 32
) (
  input  logic [DataW-1:0] rem_i,
  input  logic [DataW-1:0] quo_i,
  input  logic [DataW-1:0] dvs_i,
  output logic [DataW-1:0] rem_o,
  output logic [DataW-1:0] quo_o
);
  logic [DataW:0] shifted;
  logic [DataW:0] trial;
  logic           fits;
  logic           unused_trial_msb;

  always_comb begin
    shifted = {rem_i, quo_i[DataW-1]};
    trial   = shifted - {1'b0, dvs_i};
    fits    = (shifted >= {1'b0, dvs_i});
    // When the divisor fits the difference is below the divisor, so its top bit is always 0.
    rem_o   = fits ? trial[DataW-1:0] : shifted[DataW-1:0];
    quo_o   = {quo_i[DataW-2:0], fits};
  end

  assign unused_trial_msb = trial[DataW];

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle signed/unsigned divide/modulo sequencer (restoring, one quotient bit per cycle).
// Define DIV_EARLY_OUT_EN to skip leading-zero iterations of the dividend magnitude.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int unsigned DataW = DivDataW,
  parameter int unsigned CntW  = DivCntW
) (
  input logic          clk_i,
  input logic          rst_ni,
  div_seq_ctrl_if.slave bus
);
  div_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [DataW-1:0] rem_q, rem_d;
  logic [DataW-1:0] quo_q, quo_d;
  logic [DataW-1:0] dvs_q, dvs_d;
  logic [DataW-1:0] result_q, result_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             mod_q, mod_d;

  logic [DataW-1:0] a_abs, b_abs, quo_init, rem_step, quo_step;
  logic [CntW-1:0]  cnt_init;
  logic             accept;

  div_seq_ctrl_step #(.DataW(DataW)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_step),
    .quo_o (quo_step)
  );

  always_comb begin
    a_abs = (!bus.is_unsigned && bus.src1[DataW-1]) ? -bus.src1 : bus.src1;
    b_abs = (!bus.is_unsigned && bus.src2[DataW-1]) ? -bus.src2 : bus.src2;
  end

`ifdef DIV_EARLY_OUT_EN
  logic [CntW-1:0] lz;
  logic            lz_found;

  always_comb begin
    lz       = '0;
    lz_found = 1'b0;
    for (int i = DataW - 1; i >= 0; i--) begin
      if (!lz_found) begin
        if (a_abs[i]) lz_found = 1'b1;
        else          lz = lz + CntW'(1);
      end
    end
    // A zero dividend still runs one step so the FIX/DONE path stays uniform.
    cnt_init = CntW'(DataW) - lz;
    if (cnt_init == '0) cnt_init = CntW'(1);
    quo_init = a_abs << lz;
  end
`else
  always_comb begin
    cnt_init = CntW'(DataW);
    quo_init = a_abs;
  end
`endif

  assign accept = bus.in_valid && !bus.flush && (state_q == StIdle);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    mod_d    = mod_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          q_neg_d = !bus.is_unsigned && (bus.src1[DataW-1] ^ bus.src2[DataW-1]);
          r_neg_d = !bus.is_unsigned && bus.src1[DataW-1];
          mod_d   = bus.use_mod;
          if (bus.src2 == '0) begin
            result_d = bus.use_mod ? bus.src1 : {DataW{1'b1}};
            state_d  = StDone;
          end else begin
            dvs_d   = b_abs;
            rem_d   = '0;
            quo_d   = quo_init;
            cnt_d   = cnt_init;
            state_d = StIter;
          end
        end
      end
      StIter: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StFix;
      end
      StFix: begin
        result_d = mod_q ? (r_neg_q ? -rem_q : rem_q) : (q_neg_q ? -quo_q : quo_q);
        state_d  = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (bus.flush) begin
      state_d  = StIdle;
      result_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      mod_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      mod_q    <= mod_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Randomized plus directed bench for div_seq_ctrl against an arithmetic reference model.
module tb_div_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  div_seq_ctrl_if #(.DataW(32)) bus ();

  div_seq_ctrl dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Truncating division, remainder takes the dividend's sign; /0 and MIN/-1 follow the ISA rules.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input bit uns, input bit md);
    int sa, sb;
    if (b == 32'd0) return md ? a : 32'hFFFF_FFFF;
    if (uns) return md ? (a % b) : (a / b);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return md ? 32'd0 : 32'h8000_0000;
    sa = int'(a);
    sb = int'(b);
    return md ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input bit uns);
    logic [31:0] mag;
    int          n;
    if (b == 32'd0) return 1;
    mag = (!uns && a[31]) ? -a : a;
    n = 0;
`ifdef DIV_EARLY_OUT_EN
    while (n < 32 && !mag[31 - n]) n++;
    return ((32 - n) < 1 ? 1 : (32 - n)) + 2;
`else
    if (mag == 32'd0) n = 0;
    return 34;
`endif
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit uns,
                          input bit md);
    bus.in_valid    = 1'b1;
    bus.src1        = a;
    bus.src2        = b;
    bus.is_unsigned = uns;
    bus.use_mod     = md;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.src1     = $urandom;
    bus.src2     = $urandom;
  endtask

  // Returns cycles from the accept edge until out_valid (accept edge counts as cycle 1).
  task automatic wait_done(output int n);
    n = 1;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input bit uns, input bit md);
    int n;
    start_op(a, b, uns, md);
    wait_done(n);
    check_eq({tag, " lat"}, 32'(n), 32'(ref_lat(a, b, uns)));
    check_eq({tag, " res"}, bus.result, ref_div(a, b, uns, md));
    consume();
    check_eq({tag, " idle"}, {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
  endtask

  function automatic logic [31:0] pick_operand();
    unique case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 300));
      4: return -32'($urandom_range(1, 300));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          n;
    logic [31:0] held;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.is_unsigned = 1'b0; bus.use_mod = 1'b0; bus.src1 = '0; bus.src2 = '0;
    #12;
    check_eq("reset outs", {28'd0, bus.in_ready, bus.out_valid, bus.busy, 1'b0}, 32'h8);
    check_eq("reset result", bus.result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("s7/-2 q", 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_op("s7/-2 r", 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1);
    do_op("uFFFFFFFF/16 q", 32'hFFFF_FFFF, 32'h10, 1'b1, 1'b0);
    do_op("uFFFFFFFF/16 r", 32'hFFFF_FFFF, 32'h10, 1'b1, 1'b1);
    do_op("div0 q", 32'h1234, 32'd0, 1'b0, 1'b0);
    do_op("div0 r", 32'h1234, 32'd0, 1'b0, 1'b1);
    do_op("ovf q", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op("ovf r", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    do_op("s-7%2", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
    do_op("100/7", 32'd100, 32'd7, 1'b0, 1'b0);
    do_op("0/5", 32'd0, 32'd5, 1'b0, 1'b0);

    // Flush during iteration drops the op; a flushed in_valid is not accepted.
    start_op(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("flush idle", {30'd0, bus.in_ready, bus.busy}, 32'd2);
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) n++;
    end
    check_eq("flush no valid", 32'(n), 32'd0);
    do_op("post-flush 100/7", 32'd100, 32'd7, 1'b0, 1'b0);

    // Result must hold while the consumer stalls.
    start_op(32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0);
    wait_done(n);
    held = bus.result;
    check_eq("stall res", held, ref_div(32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0));
    n = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (!bus.out_valid || bus.result !== held) n++;
    end
    check_eq("stall stable", 32'(n), 32'd0);
    consume();

    // Asynchronous reset mid-iteration, after a nonzero result has been registered.
    start_op(32'd12345, 32'd17, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("midrst outs", {28'd0, bus.in_ready, bus.out_valid, bus.busy, 1'b0}, 32'h8);
    check_eq("midrst result", bus.result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = pick_operand();
      b = pick_operand();
      do_op($sformatf("rnd%0d", i), a, b, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
